// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Latency: n/a. Backpressure: n/a.
// Defines the FSM state encoding, the port identifiers and the default lock length.
package mem_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int LOCK_MAX_DEFAULT = 16;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: the port not granted last wins a tie; force_i favours the fetch port.
// Latency: combinational. Backpressure: a losing requester simply sees no grant and holds its request.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       force_i,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[PORT_I] && (force_i || !req[PORT_D] || last == PORT_D))
            gnt[PORT_I] = 1'b1;
        else if (req[PORT_D])
            gnt[PORT_D] = 1'b1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port (with bounded bus locking) onto one memory port.
// Latency: grant same cycle, rvalid/rdata one cycle later. Backpressure: requester holds req until gnt.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BYTE_SIZE  = 4,
    parameter int LOCK_MAX   = LOCK_MAX_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_req,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    output logic                   i_gnt,
    output logic                   i_rvalid,
    output logic [8*BYTE_SIZE-1:0] i_rdata,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic                   d_lock,
    input  logic [ADDR_WIDTH-1:0]  d_addr,
    input  logic [8*BYTE_SIZE-1:0] d_wdata,
    output logic                   d_gnt,
    output logic                   d_rvalid,
    output logic [8*BYTE_SIZE-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0]  m_addr,
    output logic                   m_we,
    output logic [8*BYTE_SIZE-1:0] m_wd,
    input  logic [8*BYTE_SIZE-1:0] m_rd
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_t state;
    logic [CW-1:0] lock_cnt;
    logic [CW-1:0] cnt_nxt;
    logic          last_gnt;
    logic          force_i;
    logic [1:0]    rr_gnt;

    arb_rr2 u_rr (
        .req     ({d_req, i_req}),
        .last    (last_gnt),
        .force_i (force_i),
        .gnt     (rr_gnt)
    );

    assign cnt_nxt = lock_cnt + 1'b1;

    // Grants are suppressed while reset is held so nothing reaches memory.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (state == LOCKED) begin
                d_gnt = d_req;
            end else begin
                i_gnt = rr_gnt[PORT_I];
                d_gnt = rr_gnt[PORT_D];
            end
        end
    end

    always_comb begin
        m_addr = '0;
        if (i_gnt)
            m_addr = i_addr;
        else if (d_gnt)
            m_addr = d_addr;
        m_we = d_gnt & d_we;
        m_wd = d_gnt ? d_wdata : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB;
            lock_cnt <= '0;
            last_gnt <= PORT_D;
            force_i  <= 1'b0;
        end else begin
            if (i_gnt)
                last_gnt <= PORT_I;
            else if (d_gnt)
                last_gnt <= PORT_D;

            case (state)
                ARB: begin
                    force_i <= 1'b0;
                    if (d_gnt && d_lock) begin
                        // A lock length of one is exhausted by the entering grant itself.
                        if (LOCK_MAX <= 1) begin
                            force_i <= 1'b1;
                        end else begin
                            state    <= LOCKED;
                            lock_cnt <= CW'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (d_gnt) begin
                        if (!d_lock) begin
                            state    <= ARB;
                            lock_cnt <= '0;
                        end else if (cnt_nxt == CW'(LOCK_MAX)) begin
                            state    <= ARB;
                            lock_cnt <= '0;
                            force_i  <= 1'b1;
                        end else begin
                            lock_cnt <= cnt_nxt;
                        end
                    end else if (!d_lock) begin
                        state    <= ARB;
                        lock_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ARB;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            i_rvalid <= i_gnt;
            d_rvalid <= d_gnt;
            if (i_gnt)
                i_rdata <= m_rd;
            if (d_gnt)
                d_rdata <= m_rd;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide memory model behind the shared port.
// Inputs change on the falling edge; grants are sampled mid-cycle, responses #1 after the rising edge.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int BS = 4;
    localparam int DW = 8 * BS;
    localparam int LM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic          d_lock;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_rd;

    logic [7:0] mem [0:255];
    logic       mem_init;
    logic [7:0] ma;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .BYTE_SIZE(BS), .LOCK_MAX(LM)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_lock   (d_lock),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_addr   (m_addr),
        .m_we     (m_we),
        .m_wd     (m_wd),
        .m_rd     (m_rd)
    );

    assign ma   = m_addr[7:0];
    assign m_rd = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= 8'h00;
            mem[8'h10] <= 8'h11;
            mem[8'h11] <= 8'h22;
            mem[8'h12] <= 8'h33;
            mem[8'h13] <= 8'h44;
        end else if (m_we) begin
            for (int k = 0; k < BS; k++)
                mem[ma + 8'(k)] <= m_wd[8*k +: 8];
        end
    end

    function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One arbitration cycle: drive, check grants and memory port, then check the response.
    task automatic cycle(input logic ir, input logic dr, input logic dl, input logic dw,
                         input logic [AW-1:0] da, input logic gi, input logic gd, input string tag);
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        i_req  = ir;
        d_req  = dr;
        d_lock = dl;
        d_we   = dw;
        d_addr = da;
        #1;
        exp_addr = gi ? i_addr : (gd ? da : '0);
        exp_data = gi ? rd_word(i_addr) : (gd ? rd_word(da) : '0);
        chk({tag, ".i_gnt"}, 64'(i_gnt), 64'(gi));
        chk({tag, ".d_gnt"}, 64'(d_gnt), 64'(gd));
        chk({tag, ".m_we"}, 64'(m_we), 64'(gd & dw));
        chk({tag, ".m_addr"}, 64'(m_addr), 64'(exp_addr));
        @(posedge clk);
        #1;
        chk({tag, ".i_rvalid"}, 64'(i_rvalid), 64'(gi));
        chk({tag, ".d_rvalid"}, 64'(d_rvalid), 64'(gd));
        if (gi)
            chk({tag, ".i_rdata"}, 64'(i_rdata), 64'(exp_data));
        if (gd)
            chk({tag, ".d_rdata"}, 64'(d_rdata), 64'(exp_data));
        @(negedge clk);
    endtask

    // {i_req, d_req, d_lock, d_we, exp_i_gnt, exp_d_gnt}; LOCK_MAX = 4, pointer last = D on entry.
    logic [5:0] lock_tbl [0:14] = '{
        6'b111010,  // tie, I wins
        6'b111001,  // D locks, cnt 1
        6'b111101,  // locked write, cnt 2
        6'b111001,  // cnt 3, reads back the locked write
        6'b111001,  // cnt 4 -> forced release
        6'b111010,  // fetch gets its turn
        6'b111001,  // data resumes and locks again
        6'b101000,  // lock held with no data request
        6'b111001,  // locked grant, fetch still blocked
        6'b100000,  // lock and request dropped -> release
        6'b100010,  // pending fetch granted
        6'b110001,  // tie after I -> D
        6'b011001,  // single D locks
        6'b110001,  // unlocked data grant releases
        6'b110010   // tie after D -> I
    };

    initial begin
        reset    = 1'b1;
        mem_init = 1'b1;
        i_req    = 1'b1;
        d_req    = 1'b1;
        d_we     = 1'b1;
        d_lock   = 1'b0;
        i_addr   = 32'h10;
        d_addr   = 32'h20;
        d_wdata  = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst.i_gnt", 64'(i_gnt), 64'd0);
        chk("rst.d_gnt", 64'(d_gnt), 64'd0);
        chk("rst.m_we", 64'(m_we), 64'd0);
        chk("rst.i_rvalid", 64'(i_rvalid), 64'd0);
        chk("rst.d_rvalid", 64'(d_rvalid), 64'd0);
        chk("rst.i_rdata", 64'(i_rdata), 64'd0);
        chk("rst.d_rdata", 64'(d_rdata), 64'd0);
        mem_init = 1'b0;
        i_req    = 1'b0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        reset    = 1'b0;
        @(negedge clk);

        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 1'b1, 1'b0, "fetch");
        chk("fetch.word", 64'(i_rdata), 64'h44332211);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 1'b0, 1'b0, "idle");
        chk("idle.i_rdata_hold", 64'(i_rdata), 64'h44332211);

        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 1'b1, "wr20");
        chk("wr20.old_data", 64'(d_rdata), 64'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 1'b0, 1'b1, "rd20");
        chk("rd20.word", 64'(d_rdata), 64'hDEADBEEF);

        // Reset lands between a grant and the edge that would capture its response.
        i_req = 1'b1;
        d_req = 1'b0;
        #1;
        chk("rstmid.pre_gnt", 64'(i_gnt), 64'd1);
        reset = 1'b1;
        #1;
        chk("rstmid.gnt_off", 64'(i_gnt), 64'd0);
        @(posedge clk);
        #1;
        chk("rstmid.i_rvalid", 64'(i_rvalid), 64'd0);
        chk("rstmid.i_rdata", 64'(i_rdata), 64'd0);
        chk("rstmid.d_rdata", 64'(d_rdata), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        i_req = 1'b0;

        for (int k = 0; k < 4; k++)
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h20, (k % 2) == 0, (k % 2) == 1,
                  $sformatf("alt%0d", k));

        d_wdata = 32'hCAFEF00D;
        for (int k = 0; k < 15; k++)
            cycle(lock_tbl[k][5], lock_tbl[k][4], lock_tbl[k][3], lock_tbl[k][2], 32'h24,
                  lock_tbl[k][1], lock_tbl[k][0], $sformatf("lock%0d", k));
        chk("lock.word24", 64'(rd_word(32'h24)), 64'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter BYTE_SIZE, default 4, bytes per access; data width DW = 8*BYTE_SIZE.
REQ-003 SHALL have parameter LOCK_MAX, default 16, max consecutive locked data grants.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports i_req input 1, i_addr input ADDR_WIDTH: instruction-fetch request (read only).
REQ-007 SHALL have ports i_gnt output 1, i_rvalid output 1, i_rdata output DW: fetch grant and registered response.
REQ-008 SHALL have ports d_req input 1, d_we input 1, d_lock input 1, d_addr input ADDR_WIDTH, d_wdata input DW: data request.
REQ-009 SHALL have ports d_gnt output 1, d_rvalid output 1, d_rdata output DW: data grant and registered response.
REQ-010 SHALL have ports m_addr output ADDR_WIDTH, m_we output 1, m_wd output DW, m_rd input DW: shared memory port (combinational read, write on clk edge).

Function
REQ-011 SHALL grant at most one requester per cycle; i_gnt and d_gnt never both 1.
REQ-012 SHALL compute grants combinationally from current req inputs and state; requester holds req/addr/data until gnt.
REQ-013 SHALL drive m_addr/m_wd from the granted port; m_we = d_gnt & d_we; with no grant m_addr = 0, m_we = 0, m_wd = 0.
REQ-014 SHALL register m_rd into the granted port's rdata and pulse its rvalid for exactly one cycle on the edge after grant (latency 1); d_rvalid pulses for writes too, d_rdata then = pre-write content.
REQ-015 SHALL hold rdata of each port unchanged when that port's rvalid is 0.
REQ-016 SHALL implement FSM states ARB and LOCKED.
REQ-017 In ARB: single requester granted; both requesting -> round-robin, port not granted last wins; last-grant pointer updates only on a grant.
REQ-018 ARB -> LOCKED on a cycle with d_gnt=1 and d_lock=1; lock counter loaded with 1.
REQ-019 In LOCKED: d_req granted every cycle it is high, i_req never granted; counter increments per data grant.
REQ-020 LOCKED -> ARB when a data grant occurs with d_lock=0, or d_req=0 and d_lock=0.
REQ-021 LOCKED -> ARB forced when counter reaches LOCK_MAX; next ARB cycle gives instruction port priority if i_req=1, regardless of pointer.
REQ-022 d_lock with d_we and d_req simultaneous in LOCKED SHALL behave as an ordinary locked write.
REQ-023 Counter width SHALL hold LOCK_MAX without wrap; counter cleared on every LOCKED -> ARB.

Reset
REQ-024 reset SHALL asynchronously force state ARB, counter 0, pointer such that instruction port wins first tie.
REQ-025 reset SHALL clear i_rvalid, d_rvalid, i_rdata, d_rdata to 0; a response pending at reset is discarded.
REQ-026 During reset all grants and m_we SHALL be 0.

Structure
REQ-027 Shared package mem_arb_pkg SHALL hold state enum (ARB, LOCKED), port-id constants (PORT_I=0, PORT_D=1), LOCK_MAX default.
REQ-028 Two-way round-robin pick SHALL be sub-module arb_rr2 (req[1:0], pointer, force_i in; one-hot gnt out); FSM, counter, muxes, response registers in mem_arbiter.

Verification
REQ-029 Only i_req, i_addr=0x10, mem[0x10..0x13]=0x44332211 -> i_gnt same cycle, next cycle i_rvalid=1, i_rdata=0x44332211.
REQ-030 i_req and d_req high 4 cycles from reset -> grants alternate I,D,I,D; i_gnt&d_gnt never 1.
REQ-031 d_req, d_we, d_addr=0x20, d_wdata=0xDEADBEEF -> m_we=1 one cycle, d_rvalid next cycle; later d_read 0x20 returns 0xDEADBEEF.
REQ-032 d_lock=1 with continuous d_req, i_req high, LOCK_MAX=4 -> 4 consecutive d_gnt, then i_gnt, then data resumes.
REQ-033 reset asserted in the cycle after a grant -> rvalid never pulses, rdata=0, state ARB, first tie grants I.
REQ-034 d_lock dropped with d_req=0 in LOCKED -> next cycle ARB, pending i_req granted.
